// File: rtl/biriscv_csr_pipe_pkg.sv
// Stage record and helpers for the CSR E2/WB pipeline.
package biriscv_csr_pipe_pkg;
    import biriscv_defs::*;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            pc;
        logic [4:0]             rd_idx;
        logic [11:0]            csr_addr;
        logic                   csr_write;
        logic [31:0]            wdata;
        logic [31:0]            value;
        logic [EXCEPTION_W-1:0] exception;
        logic [31:0]            exc_addr;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    // A fence rides the exception field to force a flush but still retires.
    function automatic logic is_fault(input logic [EXCEPTION_W-1:0] exc);
        return (exc != '0) && (exc != EXCEPTION_FENCE);
    endfunction
endpackage

// File: rtl/biriscv_defs.sv
// Shared biRISC-V exception definitions used across the core.
package biriscv_defs;
    localparam int EXCEPTION_W = 6;

    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h02;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FAULT_LOAD          = 6'h0d;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h31;
endpackage

// File: rtl/biriscv_csr_pipe_stage.sv
// One pipeline register stage: holds when disabled, loads a bubble on kill.
module biriscv_csr_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         kill,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out
);

    // Stage register with async clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_out <= '0;
        else if (enable)
            data_out <= kill ? '0 : data_in;
    end

endmodule

// File: rtl/biriscv_csr_pipe.sv
// CSR result pipeline: carries E1 CSR results through E2 and WB, merges
// memory faults, and produces single-cycle CSR and rd writebacks.
module biriscv_csr_pipe
    import biriscv_defs::*;
    import biriscv_csr_pipe_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   e1_valid_i,
    input  logic [31:0]            e1_pc_i,
    input  logic [4:0]             e1_rd_idx_i,
    input  logic [11:0]            e1_csr_addr_i,
    input  logic [31:0]            csr_result_e1_value_i,
    input  logic                   csr_result_e1_write_i,
    input  logic [31:0]            csr_result_e1_wdata_i,
    input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
    input  logic                   stall_i,
    input  logic                   squash_e1_i,
    input  logic [EXCEPTION_W-1:0] mem_exception_e2_i,
    input  logic [31:0]            mem_addr_e2_i,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [31:0]            csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [31:0]            csr_writeback_exception_pc_o,
    output logic [31:0]            csr_writeback_exception_addr_o,
    output logic                   wb_rd_valid_o,
    output logic [4:0]             wb_rd_idx_o,
    output logic [31:0]            wb_rd_value_o,
    output logic                   flush_o
);

    stage_t e1_rec;
    stage_t e2_q;
    stage_t wb_d;
    stage_t wb_q;
    logic   e2_kill;
    logic   out_en;
    logic   wb_fault;

    // Pack the E1 instruction; illegal opcodes report the opcode as the fault address
    always_comb begin
        e1_rec           = '0;
        e1_rec.valid     = 1'b1;
        e1_rec.pc        = e1_pc_i;
        e1_rec.rd_idx    = e1_rd_idx_i;
        e1_rec.csr_addr  = e1_csr_addr_i;
        e1_rec.csr_write = csr_result_e1_write_i;
        e1_rec.wdata     = csr_result_e1_wdata_i;
        e1_rec.value     = csr_result_e1_value_i;
        e1_rec.exception = csr_result_e1_exception_i;
        e1_rec.exc_addr  = (csr_result_e1_exception_i == EXCEPTION_ILLEGAL_INSTRUCTION) ?
                           csr_result_e1_value_i : 32'd0;
    end

    // Memory faults join on the E2->WB move unless E1 already raised one
    always_comb begin
        wb_d = e2_q;
        if (e2_q.valid && (e2_q.exception == '0) && (mem_exception_e2_i != '0)) begin
            wb_d.exception = mem_exception_e2_i;
            wb_d.exc_addr  = mem_addr_e2_i;
        end
    end

    assign flush_o = (e2_q.valid && (e2_q.exception != '0)) ||
                     (wb_q.valid && (wb_q.exception != '0));

    assign e2_kill = !e1_valid_i || squash_e1_i || flush_o;

    biriscv_csr_pipe_stage #(.W(STAGE_W)) u_e2 (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .enable   (!stall_i),
        .kill     (e2_kill),
        .data_in  (e1_rec),
        .data_out (e2_q)
    );

    biriscv_csr_pipe_stage #(.W(STAGE_W)) u_wb (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .enable   (!stall_i),
        .kill     (1'b0),
        .data_in  (wb_d),
        .data_out (wb_q)
    );

    // WB is presented only on the cycle it actually retires
    assign out_en   = wb_q.valid && !stall_i;
    assign wb_fault = is_fault(wb_q.exception);

    assign csr_writeback_write_o          = out_en && wb_q.csr_write && !wb_fault;
    assign csr_writeback_waddr_o          = out_en ? wb_q.csr_addr  : 12'd0;
    assign csr_writeback_wdata_o          = out_en ? wb_q.wdata     : 32'd0;
    assign csr_writeback_exception_o      = out_en ? wb_q.exception : '0;
    assign csr_writeback_exception_pc_o   = out_en ? wb_q.pc        : 32'd0;
    assign csr_writeback_exception_addr_o = out_en ? wb_q.exc_addr  : 32'd0;

    assign wb_rd_valid_o = out_en && wb_q.csr_write && (wb_q.rd_idx != 5'd0) && !wb_fault;
    assign wb_rd_idx_o   = out_en ? wb_q.rd_idx : 5'd0;
    assign wb_rd_value_o = out_en ? wb_q.value  : 32'd0;

endmodule
